// File: rtl/fsm_stim_player.sv
// Scripted stimulus player for small FSMs: plays stored symbols with a programmable hold time,
// records {symbol, resulting FSM state} pairs into a first-word-fall-through response FIFO.
module fsm_stim_player #(
  parameter int DEPTH  = 16,
  parameter int SYM_W  = 2,
  parameter int ST_W   = 4,
  parameter int HOLD_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [SYM_W-1:0]           wr_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic [HOLD_W-1:0]          hold_cycles,
  output logic [SYM_W-1:0]           fsm_in,
  output logic                       fsm_in_valid,
  input  logic [ST_W-1:0]            fsm_state,
  output logic                       rsp_valid,
  output logic [SYM_W+ST_W-1:0]      rsp_data,
  input  logic                       rsp_ready,
  output logic [$clog2(DEPTH):0]     script_count,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, TAIL} state_t;
  state_t state_reg, state_next;

  logic [SYM_W-1:0]      script_mem [DEPTH];
  logic [SYM_W+ST_W-1:0] rsp_mem    [DEPTH];

  logic [AW:0]        count_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [HOLD_W-1:0]  hold_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [SYM_W-1:0]   sym_reg;
  logic [SYM_W-1:0]   cap_sym_reg;
  logic               cap_pend_reg;
  logic               done_reg;
  logic [AW-1:0]      rsp_wr_reg;
  logic [AW-1:0]      rsp_rd_reg;
  logic [AW:0]        rsp_cnt_reg;

  logic          go, go_empty, sym_last, script_last, wr_ok, rsp_push, rsp_pop;
  logic [AW:0]   last_idx;
  logic [AW-1:0] rd_ptr_inc;

  always_comb begin
    go          = (state_reg == IDLE) && start && (count_reg != '0);
    go_empty    = (state_reg == IDLE) && start && (count_reg == '0);
    sym_last    = (state_reg == PLAY) && (hold_cnt_reg == hold_reg);
    last_idx    = count_reg - (AW+1)'(1);
    script_last = ({1'b0, rd_ptr_reg} == last_idx);
    rd_ptr_inc  = rd_ptr_reg + AW'(1);
    wr_ok       = (state_reg == IDLE) && !go && !clear && wr_en && (count_reg != FULL_CNT);
    // The capture cycle is the one right after a symbol's final cycle.
    rsp_push    = cap_pend_reg;
    rsp_pop     = rsp_ready && (rsp_cnt_reg != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = PLAY;
      PLAY:    if (sym_last && script_last) state_next = TAIL;
      TAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fsm_in       = (state_reg == PLAY) ? sym_reg : '0;
    fsm_in_valid = (state_reg == PLAY);
    busy         = (state_reg != IDLE);
    done         = done_reg;
    script_count = count_reg;
    rsp_valid    = (rsp_cnt_reg != '0);
    rsp_data     = (rsp_cnt_reg != '0) ? rsp_mem[rsp_rd_reg] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      hold_reg     <= '0;
      hold_cnt_reg <= '0;
      sym_reg      <= '0;
      cap_sym_reg  <= '0;
      cap_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && !go && clear) count_reg <= '0;
      else if (wr_ok)                          count_reg <= count_reg + (AW+1)'(1);

      if (go) begin
        hold_reg     <= hold_cycles;
        rd_ptr_reg   <= '0;
        hold_cnt_reg <= '0;
        sym_reg      <= script_mem[0];
      end else if (state_reg == PLAY) begin
        if (sym_last) begin
          hold_cnt_reg <= '0;
          if (!script_last) begin
            rd_ptr_reg <= rd_ptr_inc;
            sym_reg    <= script_mem[rd_ptr_inc];
          end
        end else begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
      end

      cap_pend_reg <= sym_last;
      if (sym_last) cap_sym_reg <= sym_reg;
      done_reg <= go_empty || (state_reg == TAIL);
    end
  end

  // Response FIFO pointers; start flushes whatever a previous run left behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_reg  <= '0;
      rsp_rd_reg  <= '0;
      rsp_cnt_reg <= '0;
    end else if (go) begin
      rsp_wr_reg  <= '0;
      rsp_rd_reg  <= '0;
      rsp_cnt_reg <= '0;
    end else begin
      if (rsp_push) rsp_wr_reg <= rsp_wr_reg + AW'(1);
      if (rsp_pop)  rsp_rd_reg <= rsp_rd_reg + AW'(1);
      if (rsp_push && !rsp_pop)      rsp_cnt_reg <= rsp_cnt_reg + (AW+1)'(1);
      else if (!rsp_push && rsp_pop) rsp_cnt_reg <= rsp_cnt_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)    script_mem[count_reg[AW-1:0]] <= wr_data;
    if (rsp_push) rsp_mem[rsp_wr_reg]           <= {cap_sym_reg, fsm_state};
  end

endmodule
